// File: rtl/fifo_ctrl_if.sv
// fifo_ctrl_if: push/pop requests and the pointer/flag status of the FIFO controller.
interface fifo_ctrl_if #(parameter int ADDRW = 2);
    logic             i_push;
    logic             i_pop;
    logic             o_wen;
    logic [ADDRW-1:0] o_waddr;
    logic [ADDRW-1:0] o_raddr;
    logic             o_full;
    logic             o_empty;
    logic [ADDRW:0]   o_count;
    logic             o_ovf;
    logic             o_udf;
    modport master (
        output i_push, i_pop,
        input  o_wen, o_waddr, o_raddr, o_full, o_empty, o_count, o_ovf, o_udf
    );
    modport slave (
        input  i_push, i_pop,
        output o_wen, o_waddr, o_raddr, o_full, o_empty, o_count, o_ovf, o_udf
    );
endinterface

// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer and flag controller for a single-clock FIFO built around regfile.
module fifo_ctrl #(
    parameter int ADDRW = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    fifo_ctrl_if.slave  bus
);
    logic [ADDRW:0] wptr, rptr;
    logic           ovf, udf;
    logic           push_ok, pop_ok;
    // reset gating keeps the regfile write off while pointers are being forced
    assign push_ok     = bus.i_push & ~bus.o_full & i_rst_n;
    assign pop_ok      = bus.i_pop & ~bus.o_empty;
    assign bus.o_wen   = push_ok;
    assign bus.o_waddr = wptr[ADDRW-1:0];
    assign bus.o_raddr = rptr[ADDRW-1:0];
    assign bus.o_empty = wptr == rptr;
    assign bus.o_full  = (wptr[ADDRW] != rptr[ADDRW]) & (wptr[ADDRW-1:0] == rptr[ADDRW-1:0]);
    assign bus.o_count = wptr - rptr;
    assign bus.o_ovf   = ovf;
    assign bus.o_udf   = udf;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wptr <= '0;
            rptr <= '0;
            ovf  <= 1'b0;
            udf  <= 1'b0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok) rptr <= rptr + 1'b1;
            ovf <= ovf | (bus.i_push & bus.o_full);
            udf <= udf | (bus.i_pop & bus.o_empty);
        end
    end
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: scoreboard bench with a bench-side regfile driven by o_wen/o_waddr/o_raddr.
module tb_fifo_ctrl;
    localparam int ADDRW = 2;
    localparam int DEPTH = 1 << ADDRW;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int errors = 0;
    int checks = 0;
    int mcount = 0, mw = 0, mr = 0;
    bit movf = 0, mudf = 0;
    int q[$];
    logic [7:0] mem [DEPTH];
    fifo_ctrl_if #(.ADDRW(ADDRW)) bus ();
    fifo_ctrl #(.ADDRW(ADDRW)) dut (.i_clk(clk), .i_rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask
    task automatic check_state();
        check("count", int'(bus.o_count), mcount);
        check("empty", int'(bus.o_empty), int'(mcount == 0));
        check("full", int'(bus.o_full), int'(mcount == DEPTH));
        check("ovf", int'(bus.o_ovf), int'(movf));
        check("udf", int'(bus.o_udf), int'(mudf));
        check("waddr", int'(bus.o_waddr), mw % DEPTH);
        check("raddr", int'(bus.o_raddr), mr % DEPTH);
        check("excl", int'(bus.o_full & bus.o_empty), 0);
    endtask
    // one clock cycle: drive, check combinational outputs, emulate regfile, advance model
    task automatic cycle(input bit p, input bit r, input int d);
        bit pok, rok;
        int exp;
        @(negedge clk);
        bus.i_push = p;
        bus.i_pop  = r;
        #1;
        pok = p && mcount < DEPTH;
        rok = r && mcount > 0;
        check_state();
        check("wen", int'(bus.o_wen), int'(pok));
        if (rok) begin
            exp = q.pop_front();
            check("rdata", int'(mem[bus.o_raddr]), exp);
        end
        if (bus.o_wen) mem[bus.o_waddr] = d[7:0];
        if (pok) q.push_back(d & 255);
        movf = movf | (p && mcount == DEPTH);
        mudf = mudf | (r && mcount == 0);
        mcount = mcount + int'(pok) - int'(rok);
        mw = (mw + int'(pok)) % (2 * DEPTH);
        mr = (mr + int'(rok)) % (2 * DEPTH);
    endtask
    initial begin
        bus.i_push = 1'b0;
        bus.i_pop  = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_state();
        check("wen_rst", int'(bus.o_wen), 0);
        rst_n = 1'b1;
        // fill to full, then overflow
        cycle(1, 0, 1);
        cycle(1, 0, 2);
        cycle(1, 0, 3);
        cycle(1, 0, 0);
        cycle(1, 0, 9);
        // drain to empty, then underflow
        for (int i = 0; i < DEPTH + 1; i++) cycle(0, 1, 0);
        cycle(0, 0, 0);
        // simultaneous push/pop while empty
        cycle(1, 1, 42);
        cycle(0, 0, 0);
        // mid-stream asynchronous reset with 3 entries held
        cycle(1, 0, 5);
        cycle(1, 0, 6);
        cycle(0, 0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        bus.i_push = 1'b1;
        #1;
        q.delete();
        mcount = 0; mw = 0; mr = 0; movf = 0; mudf = 0;
        check_state();
        check("wen_rst", int'(bus.o_wen), 0);
        @(negedge clk);
        bus.i_push = 1'b0;
        rst_n = 1'b1;
        // wrap-around with interleaved push/pop over 10 items
        for (int i = 0; i < 10; i++) begin
            cycle(1, 0, 100 + i);
            cycle(0, 1, 0);
        end
        // simultaneous at count 2, then at full
        cycle(1, 0, 11);
        cycle(1, 0, 12);
        cycle(1, 1, 13);
        cycle(1, 1, 14);
        cycle(1, 0, 15);
        cycle(1, 0, 16);
        cycle(1, 1, 17);
        cycle(0, 0, 0);
        // random soak
        for (int i = 0; i < 10000; i++)
            cycle(1'($urandom_range(1)), 1'($urandom_range(1)), int'($urandom_range(255)));
        cycle(0, 0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
